// File: rtl/ram_bist_pkg.sv
// ram_bist_pkg: shared definitions for the RAM self-test controller.
//   - FSM state encoding (state_t and the St* constants)
//   - Pattern indices, the pattern count and the pattern generator function
// Optional feature macro: RAM_BIST_CHECKERBOARD_EN adds the 16'hAAAA/16'h5555 checkerboard
// pattern, so four patterns run instead of three.
package ram_bist_pkg;

    typedef logic [2:0] state_t;

    localparam state_t StIdle  = 3'd0;
    localparam state_t StWrite = 3'd1;
    localparam state_t StRead  = 3'd2;
    localparam state_t StDrain = 3'd3;
    localparam state_t StNext  = 3'd4;
    localparam state_t StDone  = 3'd5;

    typedef logic [1:0] pat_idx_t;

    localparam pat_idx_t PatZeros = 2'd0;
    localparam pat_idx_t PatOnes  = 2'd1;
    localparam pat_idx_t PatAddr  = 2'd2;
`ifdef RAM_BIST_CHECKERBOARD_EN
    localparam pat_idx_t PatCheck = 2'd3;
    localparam int unsigned NumPatterns = 4;
`else
    localparam int unsigned NumPatterns = 3;
`endif
    localparam pat_idx_t PatLast = pat_idx_t'(NumPatterns - 1);

    // Generator works on a 64-bit word; callers truncate to their data width.
    localparam int unsigned PatWordW = 64;

    function automatic logic [PatWordW-1:0] pattern_word(input pat_idx_t idx,
                                                         input logic [PatWordW-1:0] addr);
        logic [PatWordW-1:0] w;
        w = '0;
        case (idx)
            PatZeros: w = '0;
            PatOnes:  w = '1;
            PatAddr:  w = addr;
`ifdef RAM_BIST_CHECKERBOARD_EN
            PatCheck: w = addr[0] ? 64'h0000_0000_0000_5555 : 64'h0000_0000_0000_AAAA;
`endif
            default:  w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/ram_bist_rd_pipe.sv
// ram_bist_rd_pipe: RD_LAT-deep shift register carrying {valid, address, expected word}
// alongside outstanding RAM reads, so the compare lines up with mem_q.
// Ports:
//   clock, aclr        - clock and asynchronous active-high reset (clears valid bits)
//   push_valid_i/...   - entry captured every cycle at the head
//   pop_valid_o/...    - entry leaving the tail, RD_LAT cycles after it was pushed
module ram_bist_rd_pipe #(
    parameter int unsigned RD_LAT = 2,
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clock,
    input  logic              aclr,
    input  logic              push_valid_i,
    input  logic [ADDR_W-1:0] push_addr_i,
    input  logic [DATA_W-1:0] push_exp_i,
    output logic              pop_valid_o,
    output logic [ADDR_W-1:0] pop_addr_o,
    output logic [DATA_W-1:0] pop_exp_o
);

    logic [RD_LAT-1:0]             valid_q, valid_d;
    logic [RD_LAT-1:0][ADDR_W-1:0] addr_q, addr_d;
    logic [RD_LAT-1:0][DATA_W-1:0] exp_q, exp_d;

    always_comb begin
        valid_d    = valid_q;
        addr_d     = addr_q;
        exp_d      = exp_q;
        valid_d[0] = push_valid_i;
        addr_d[0]  = push_addr_i;
        exp_d[0]   = push_exp_i;
        for (int unsigned i = 1; i < RD_LAT; i++) begin
            valid_d[i] = valid_q[i-1];
            addr_d[i]  = addr_q[i-1];
            exp_d[i]   = exp_q[i-1];
        end
    end

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            valid_q <= '0;
            addr_q  <= '0;
            exp_q   <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            exp_q   <= exp_d;
        end
    end

    assign pop_valid_o = valid_q[RD_LAT-1];
    assign pop_addr_o  = addr_q[RD_LAT-1];
    assign pop_exp_o   = exp_q[RD_LAT-1];

endmodule

// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl: self-test initiator for a single-port RAM. On start it writes and then
// reads back every address with each data pattern, counting mismatches.
// Optional feature macro: RAM_BIST_CHECKERBOARD_EN (adds a fourth, checkerboard pattern).
// Ports:
//   clock, aclr      - clock and asynchronous active-high reset
//   start            - test request, honoured only while idle
//   busy, done       - test in progress / one-cycle end-of-test pulse
//   pass, error_cnt, first_err_addr - results, held until the next accepted start
//   mem_address, mem_data, mem_wren - registered RAM controls
//   mem_q            - RAM read data, valid RD_LAT cycles after the address
module ram_bist_ctrl
    import ram_bist_pkg::*;
#(
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned RD_LAT = 2
) (
    input  logic              clock,
    input  logic              aclr,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       error_cnt,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q
);

    localparam logic [ADDR_W-1:0] AddrLast = '1;
    localparam logic [2:0]        DrainLast = 3'(RD_LAT - 1);

    state_t            state_q, state_d;
    pat_idx_t          pat_q, pat_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        drain_q, drain_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              wren_q, wren_d;
    logic [15:0]       err_q, err_d;
    logic [ADDR_W-1:0] first_q, first_d;
    logic              pass_q, pass_d;

    logic              push_valid;
    logic [DATA_W-1:0] push_exp;
    logic              rd_valid;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_exp;

    function automatic logic [DATA_W-1:0] word_at(input pat_idx_t p,
                                                  input logic [ADDR_W-1:0] a);
        logic [PatWordW-1:0] w;
        w = pattern_word(p, PatWordW'(a));
        return w[DATA_W-1:0];
    endfunction

    // Every READ cycle issues one address; its expected word travels with it.
    assign push_valid = (state_q == StRead);
    assign push_exp   = word_at(pat_q, addr_q);

    ram_bist_rd_pipe #(
        .RD_LAT (RD_LAT),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_rd_pipe (
        .clock        (clock),
        .aclr         (aclr),
        .push_valid_i (push_valid),
        .push_addr_i  (addr_q),
        .push_exp_i   (push_exp),
        .pop_valid_o  (rd_valid),
        .pop_addr_o   (rd_addr),
        .pop_exp_o    (rd_exp)
    );

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        addr_d  = addr_q;
        drain_d = drain_q;
        data_d  = '0;
        wren_d  = 1'b0;
        err_d   = err_q;
        first_d = first_q;
        pass_d  = pass_q;

        if (rd_valid && (mem_q != rd_exp)) begin
            if (err_q != 16'hFFFF) begin
                err_d = err_q + 16'd1;
            end
            // A zero count means no mismatch has been seen yet in this test.
            if (err_q == 16'd0) begin
                first_d = rd_addr;
            end
        end

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StWrite;
                    pat_d   = PatZeros;
                    addr_d  = '0;
                    wren_d  = 1'b1;
                    data_d  = word_at(PatZeros, '0);
                    err_d   = '0;
                    first_d = '0;
                    pass_d  = 1'b0;
                end
            end
            StWrite: begin
                if (addr_q == AddrLast) begin
                    state_d = StRead;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + 1'b1;
                    wren_d = 1'b1;
                    data_d = word_at(pat_q, addr_q + 1'b1);
                end
            end
            StRead: begin
                if (addr_q == AddrLast) begin
                    state_d = StDrain;
                    addr_d  = '0;
                    drain_d = '0;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            StDrain: begin
                if (drain_q == DrainLast) begin
                    state_d = StNext;
                end else begin
                    drain_d = drain_q + 3'd1;
                end
            end
            StNext: begin
                if (pat_q != PatLast) begin
                    state_d = StWrite;
                    pat_d   = pat_q + 2'd1;
                    addr_d  = '0;
                    wren_d  = 1'b1;
                    data_d  = word_at(pat_q + 2'd1, '0);
                end else begin
                    // Delay line is empty here, so the count is final.
                    state_d = StDone;
                    pass_d  = (err_q == 16'd0);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            state_q <= StIdle;
            pat_q   <= PatZeros;
            addr_q  <= '0;
            drain_q <= '0;
            data_q  <= '0;
            wren_q  <= 1'b0;
            err_q   <= '0;
            first_q <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            addr_q  <= addr_d;
            drain_q <= drain_d;
            data_q  <= data_d;
            wren_q  <= wren_d;
            err_q   <= err_d;
            first_q <= first_d;
            pass_q  <= pass_d;
        end
    end

    assign busy           = (state_q == StWrite) || (state_q == StRead) ||
                            (state_q == StDrain) || (state_q == StNext);
    assign done           = (state_q == StDone);
    assign pass           = pass_q;
    assign error_cnt      = err_q;
    assign first_err_addr = first_q;
    assign mem_address    = addr_q;
    assign mem_data       = data_q;
    assign mem_wren       = wren_q;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
module tb_ram_bist_ctrl;

`ifdef RAM_BIST_CHECKERBOARD_EN
    localparam int NPAT      = 4;
    localparam int ERR_STUCK = 32;
    localparam int ERR_ALIAS = 2;
`else
    localparam int NPAT      = 3;
    localparam int ERR_STUCK = 24;
    localparam int ERR_ALIAS = 1;
`endif
    localparam int PAT_LEN = 2 * 16 + 2 + 1;

    logic        clock;
    logic        aclr;
    logic        start;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] error_cnt;
    logic [3:0]  first_err_addr;
    logic [3:0]  mem_address;
    logic [15:0] mem_data;
    logic        mem_wren;
    logic [15:0] mem_q;

    ram_bist_ctrl #(
        .ADDR_W (4),
        .DATA_W (16),
        .RD_LAT (2)
    ) dut (
        .clock          (clock),
        .aclr           (aclr),
        .start          (start),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .error_cnt      (error_cnt),
        .first_err_addr (first_err_addr),
        .mem_address    (mem_address),
        .mem_data       (mem_data),
        .mem_wren       (mem_wren),
        .mem_q          (mem_q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural RAM, read latency 2. fault_mode: 0 good, 1 data bit 3 stuck at 0,
    // 2 address 5 aliased onto 4.
    int          fault_mode;
    logic [15:0] ram [16];
    logic [15:0] q1;
    logic [3:0]  eff_addr;

    assign eff_addr = (fault_mode == 2 && mem_address == 4'd5) ? 4'd4 : mem_address;

    initial begin
        for (int i = 0; i < 16; i++) ram[i] = 16'h0;
    end

    always @(posedge clock) begin
        if (mem_wren) ram[eff_addr] <= (fault_mode == 1) ? (mem_data & ~16'h0008) : mem_data;
        q1    <= ram[eff_addr];
        mem_q <= q1;
    end

    int n_checks;
    int n_pass;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    typedef struct {
        int fault;
        bit restart;
        int exp_busy;
        int exp_done;
        bit exp_pass;
        int exp_err;
        int exp_first;
    } vec_t;

    vec_t        vecs[4];
    logic [15:0] wr_top[4];

    task automatic run_test(input int fault, input bit restart, output int busy_cycles,
                            output int done_cnt, output bit timed_out);
        bit seen;
        int left;
        int wpass;
        fault_mode  = fault;
        busy_cycles = 0;
        done_cnt    = 0;
        timed_out   = 1'b1;
        seen        = 1'b0;
        left        = 0;
        wpass       = 0;
        @(negedge clock);
        start = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clock);
            if (busy) busy_cycles++;
            if (mem_wren && mem_address == 4'd15 && wpass < 4) begin
                wr_top[wpass] = mem_data;
                wpass++;
            end
            start = restart && (c >= 40) && (c < 43);
            if (done) begin
                done_cnt++;
                if (!seen) begin
                    seen = 1'b1;
                    left = 4;
                end
            end
            if (seen) begin
                if (left == 0) begin
                    timed_out = 1'b0;
                    break;
                end
                left--;
            end
        end
        start = 1'b0;
    endtask

    int  bc, dc, cnt_done;
    bit  to;

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        fault_mode = 0;
        start      = 1'b0;
        aclr       = 1'b1;

        vecs[0] = '{0, 1'b0, NPAT * PAT_LEN, 1, 1'b1, 0,         0};
        vecs[1] = '{1, 1'b0, NPAT * PAT_LEN, 1, 1'b0, ERR_STUCK, 0};
        vecs[2] = '{2, 1'b0, NPAT * PAT_LEN, 1, 1'b0, ERR_ALIAS, 4};
        vecs[3] = '{0, 1'b1, NPAT * PAT_LEN, 1, 1'b1, 0,         0};

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_pass", 32'(pass), 0);
        check("rst_wren", 32'(mem_wren), 0);
        check("rst_err", 32'(error_cnt), 0);
        check("rst_first", 32'(first_err_addr), 0);
        check("rst_addr", 32'(mem_address), 0);
        check("rst_data", 32'(mem_data), 0);
        aclr = 1'b0;

        // First cycle after start, then async reset during the P1 write pass
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("start_busy", 32'(busy), 1);
        check("start_wren", 32'(mem_wren), 1);
        check("start_addr", 32'(mem_address), 0);
        check("start_data", 32'(mem_data), 0);
        repeat (40) @(negedge clock);
        check("p1w_wren", 32'(mem_wren), 1);
        check("p1w_addr", 32'(mem_address), 5);
        check("p1w_data", 32'(mem_data), 32'hFFFF);
        #2 aclr = 1'b1;
        #1;
        check("aclr_wren_async", 32'(mem_wren), 0);
        check("aclr_busy_async", 32'(busy), 0);
        @(negedge clock);
        aclr = 1'b0;

        // Async reset during the P1 read pass with a faulty RAM
        fault_mode = 1;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (60) @(negedge clock);
        check("p1r_wren", 32'(mem_wren), 0);
        check("p1r_err_partial", 32'(error_cnt), 7);
        #2 aclr = 1'b1;
        #1;
        check("aclr_err_clr", 32'(error_cnt), 0);
        check("aclr_first_clr", 32'(first_err_addr), 0);
        check("aclr_busy", 32'(busy), 0);
        @(negedge clock);
        aclr     = 1'b0;
        cnt_done = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (done || busy) cnt_done++;
        end
        check("aclr_no_done", 32'(cnt_done), 0);

        // Table-driven full runs (results of one row must be cleared by the next start)
        for (int v = 0; v < 4; v++) begin
            run_test(vecs[v].fault, vecs[v].restart, bc, dc, to);
            check($sformatf("v%0d_timeout", v), 32'(to), 0);
            check($sformatf("v%0d_busy_cycles", v), 32'(bc), 32'(vecs[v].exp_busy));
            check($sformatf("v%0d_done_cnt", v), 32'(dc), 32'(vecs[v].exp_done));
            check($sformatf("v%0d_pass", v), 32'(pass), 32'(vecs[v].exp_pass));
            check($sformatf("v%0d_err", v), 32'(error_cnt), 32'(vecs[v].exp_err));
            check($sformatf("v%0d_first", v), 32'(first_err_addr), 32'(vecs[v].exp_first));
            if (v == 0) begin
                check("top_word_p0", 32'(wr_top[0]), 32'h0);
                check("top_word_p1", 32'(wr_top[1]), 32'hFFFF);
                check("top_word_p2", 32'(wr_top[2]), 32'd15);
            end
        end

        // Results hold while idle; start ignored checks above are in row 3
        repeat (10) @(negedge clock);
        check("hold_pass", 32'(pass), 1);
        check("hold_busy", 32'(busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
